risc16_pc: RTL and testbench
============================

Name: risc16_pc

Overview:
- Program-counter register for the RiSC-16 single-cycle datapath.
- On each rising clock edge it loads the next fetch address from one of three candidates:
  - sequential PC+1;
  - branch target PC+1+imm;
  - jump target from the ALU (JALR).
- Its output drives instruction-memory address and the PC+1 / branch adders upstream.

Parameters:
- WIDTH, 16, address/data word width in bits.
- RESET_VAL, 16'h0000, value loaded into the PC on reset.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- MUX_output  input  2  next-PC source select (encoding below).
- pc_plus1  input  WIDTH  sequential next address (current PC + 1), computed externally.
- pc_plus1_imm  input  WIDTH  branch target (PC + 1 + sign-extended imm), computed externally.
- alu_out  input  WIDTH  jump target (register value via ALU pass-through).
- nxt_instr  output  WIDTH  current PC register value = address of instruction being fetched.

Behaviour:
- Single WIDTH-bit register; nxt_instr is driven directly from the register. No combinational path from inputs to output.
- Reset:
  - At a rising clk edge with rst=1, the register loads RESET_VAL (0x0000).
  - Reset has priority over any select value.
  - No effect between edges (reset is synchronous).
  - Reset asserted mid-sequence discards the pending select on that edge.
- Normal update, at a rising clk edge with rst=0, the register loads:
  - MUX_output=2'b00 -> pc_plus1
  - MUX_output=2'b01 -> pc_plus1_imm
  - MUX_output=2'b10 -> alu_out
  - MUX_output=2'b11 -> pc_plus1 (reserved code, same as sequential increment; never holds, never selects another source)
- Latency: exactly one cycle from select/data inputs to nxt_instr. The new value is visible after the edge and stable for the whole following cycle.
- Non-selected inputs have no effect, regardless of value.
- Arithmetic: none inside the block. Values pass through unchanged and wrap-around is the responsibility of the upstream adders (e.g. pc_plus1=0x0000 after 0xFFFF loads 0x0000).
- X/unknown select: in simulation, treated as the default branch (pc_plus1). No assertions inside RTL.
- Back-to-back different selects on consecutive cycles are each honoured on their own edge; no stall/hold state exists.
- Before the first reset the register value is unspecified; the system must reset before use.

Decomposition:
- Shared package risc16_pkg holds:
  - WORD_W = 16;
  - a 2-bit enum pc_sel_e with PC_SEL_PLUS1 = 2'b00, PC_SEL_IMM = 2'b01, PC_SEL_ALU = 2'b10, PC_SEL_RSVD = 2'b11.
- The control unit uses the same enum to drive MUX_output.
- No sub-module: a single case-statement next-value selection feeding one register.
- Include a lightweight assertion/cover block (ifdef'd out for synthesis) for:
  - covering each select code;
  - checking one-cycle latency against a reference model.

Test Plan:
- Reset: rst=1 for one rising edge with arbitrary inputs -> nxt_instr=0x0000; with rst=1 held and MUX_output=2'b10, alu_out=0xABCD -> stays 0x0000.
- Sequential: rst=0, sel=00, pc_plus1=0x0001 then 0x0002 on consecutive edges -> nxt_instr 0x0001 then 0x0002.
- Branch: sel=01, pc_plus1_imm=0x1234, pc_plus1=0xFFFF, alu_out=0xEEEE -> 0x1234. Jump: sel=10, alu_out=0xABCD, others 0xFFFF/0xEEEE -> 0xABCD.
- Back-to-back, one edge each:
  - sel=00, pc_plus1=0xABCE -> 0xABCE
  - sel=10, alu_out=0xBEEF -> 0xBEEF
  - sel=01, pc_plus1_imm=0xCAFE -> 0xCAFE
- Reserved select: sel=11, pc_plus1=0x0009, pc_plus1_imm=0x000A, alu_out=0x000B -> 0x0009.
- Mid-operation reset: after PC=0x0009, assert rst for one edge -> 0x0000; deassert with sel=00, pc_plus1=0x0001 -> 0x0001 on next edge.

Source files
------------

// File: rtl/risc16_pkg.sv
// Shared RiSC-16 definitions: word width and the next-PC source encoding
// driven by the control unit onto the PC mux select.
package risc16_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    PC_SEL_PLUS1 = 2'b00,  // sequential fetch
    PC_SEL_IMM   = 2'b01,  // taken branch, PC + 1 + imm
    PC_SEL_ALU   = 2'b10,  // JALR target from the ALU
    PC_SEL_RSVD  = 2'b11   // unused code, behaves as sequential fetch
  } pc_sel_e;

endpackage : risc16_pkg

// File: rtl/risc16_pc.sv
// RiSC-16 program-counter register. Picks the next fetch address from the
// sequential, branch or jump candidate and presents it one cycle later.
// All arithmetic lives in the upstream adders; values pass straight through.
module risc16_pc
  import risc16_pkg::*;
#(
  parameter int               WIDTH     = WORD_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       MUX_output,
  input  logic [WIDTH-1:0] pc_plus1,
  input  logic [WIDTH-1:0] pc_plus1_imm,
  input  logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] nxt_instr
);

  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_q;

  // Next-PC selection; the reserved code and any unknown select fall back to
  // the sequential address so the PC never holds or stalls.
  always_comb begin
    pc_d = pc_plus1;
    case (pc_sel_e'(MUX_output))
      PC_SEL_PLUS1: pc_d = pc_plus1;
      PC_SEL_IMM:   pc_d = pc_plus1_imm;
      PC_SEL_ALU:   pc_d = alu_out;
      PC_SEL_RSVD:  pc_d = pc_plus1;
      default:      pc_d = pc_plus1;
    endcase
  end

  // PC register; synchronous reset wins over any pending select.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VAL;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign nxt_instr = pc_q;

`ifndef SYNTHESIS
  // Simulation-only observation: select coverage and a one-cycle latency
  // reference built from the inputs sampled at the previous edge.
  logic seen_rst_q;

  // Latches once the first reset edge has been seen; the PC is undefined before.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_rst_q <= 1'b1;
    end else begin
      seen_rst_q <= seen_rst_q;
    end
  end

  cov_sel_plus1: cover property (@(posedge clk) !rst && MUX_output == PC_SEL_PLUS1);
  cov_sel_imm:   cover property (@(posedge clk) !rst && MUX_output == PC_SEL_IMM);
  cov_sel_alu:   cover property (@(posedge clk) !rst && MUX_output == PC_SEL_ALU);
  cov_sel_rsvd:  cover property (@(posedge clk) !rst && MUX_output == PC_SEL_RSVD);

  ast_reset: assert property (@(posedge clk)
    (seen_rst_q && $past(rst)) |-> (nxt_instr == RESET_VAL));
  ast_plus1: assert property (@(posedge clk)
    (seen_rst_q && !$past(rst) && ($past(MUX_output) == 2'b00 || $past(MUX_output) == 2'b11))
      |-> (nxt_instr == $past(pc_plus1)));
  ast_imm: assert property (@(posedge clk)
    (seen_rst_q && !$past(rst) && $past(MUX_output) == 2'b01)
      |-> (nxt_instr == $past(pc_plus1_imm)));
  ast_alu: assert property (@(posedge clk)
    (seen_rst_q && !$past(rst) && $past(MUX_output) == 2'b10)
      |-> (nxt_instr == $past(alu_out)));
`endif

endmodule : risc16_pc

// File: tb/tb_risc16_pc.sv
// Directed bench for risc16_pc: each vector is applied for one rising edge
// and the PC is compared against a hand-computed expected value.
module tb_risc16_pc;

  logic        clk;
  logic        rst;
  logic [1:0]  MUX_output;
  logic [15:0] pc_plus1;
  logic [15:0] pc_plus1_imm;
  logic [15:0] alu_out;
  logic [15:0] nxt_instr;

  int checks_cnt;
  int fail_cnt;

  risc16_pc #(
    .WIDTH     (16),
    .RESET_VAL (16'h0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .MUX_output   (MUX_output),
    .pc_plus1     (pc_plus1),
    .pc_plus1_imm (pc_plus1_imm),
    .alu_out      (alu_out),
    .nxt_instr    (nxt_instr)
  );

  // 10-time-unit free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Apply one vector before an edge, then sample one time unit after it.
  task automatic step(input string tag, input logic r, input logic [1:0] sel,
                      input logic [15:0] p1, input logic [15:0] pimm,
                      input logic [15:0] alu, input logic [15:0] exp);
    rst          = r;
    MUX_output   = sel;
    pc_plus1     = p1;
    pc_plus1_imm = pimm;
    alu_out      = alu;
    @(posedge clk);
    #1;
    check_eq(tag, nxt_instr, exp);
  endtask

  initial begin
    checks_cnt   = 0;
    fail_cnt     = 0;
    rst          = 1'b1;
    MUX_output   = 2'b00;
    pc_plus1     = 16'h0000;
    pc_plus1_imm = 16'h0000;
    alu_out      = 16'h0000;
    @(negedge clk);

    // Reset with arbitrary inputs, then held reset with a jump pending.
    step("reset",        1'b1, 2'b01, 16'h1111, 16'h2222, 16'h3333, 16'h0000);
    step("reset_hold",   1'b1, 2'b10, 16'h1111, 16'h2222, 16'hABCD, 16'h0000);

    // Sequential fetch.
    step("seq_1",        1'b0, 2'b00, 16'h0001, 16'h7777, 16'h8888, 16'h0001);
    step("seq_2",        1'b0, 2'b00, 16'h0002, 16'h7777, 16'h8888, 16'h0002);

    // Branch and jump with the other candidates holding distinct values.
    step("branch",       1'b0, 2'b01, 16'hFFFF, 16'h1234, 16'hEEEE, 16'h1234);
    step("jump",         1'b0, 2'b10, 16'hFFFF, 16'hEEEE, 16'hABCD, 16'hABCD);

    // Output must not follow input changes between edges.
    MUX_output   = 2'b01;
    pc_plus1_imm = 16'h5A5A;
    alu_out      = 16'h0F0F;
    #2;
    check_eq("stable_mid",  nxt_instr, 16'hABCD);

    // Back-to-back different selects.
    step("b2b_seq",      1'b0, 2'b00, 16'hABCE, 16'h1111, 16'h2222, 16'hABCE);
    step("b2b_alu",      1'b0, 2'b10, 16'h3333, 16'h4444, 16'hBEEF, 16'hBEEF);
    step("b2b_imm",      1'b0, 2'b01, 16'h5555, 16'hCAFE, 16'h6666, 16'hCAFE);

    // Reserved code behaves as sequential fetch.
    step("rsvd",         1'b0, 2'b11, 16'h0009, 16'h000A, 16'h000B, 16'h0009);

    // Mid-operation reset discards the pending jump; then resume.
    step("mid_reset",    1'b1, 2'b10, 16'h0010, 16'h0011, 16'h5555, 16'h0000);
    step("after_reset",  1'b0, 2'b00, 16'h0001, 16'h0002, 16'h0003, 16'h0001);

    // Wrap-around is purely pass-through.
    step("top_addr",     1'b0, 2'b00, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF);
    step("wrap",         1'b0, 2'b00, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000);

    // Jump to all-ones then branch to a different pattern.
    step("jump_ones",    1'b0, 2'b10, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
    step("branch_alt",   1'b0, 2'b01, 16'hFFFF, 16'h5AA5, 16'hFFFF, 16'h5AA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule : tb_risc16_pc
